// File: rtl/fetch_queue_unit_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
//   fetch_entry_t  - one queued fetch result {pc, ir, iam, iaf}
//   fetch_state_e  - fetch sequencer states
//   PC_INC         - sequential fetch stride in bytes
// The entry is sized for the widest supported configuration (64-bit PC,
// 32-bit instruction). Narrower XLEN/ILEN settings zero-extend into it.
package fetch_pkg;

    localparam int unsigned FETCH_XLEN = 64;
    localparam int unsigned FETCH_ILEN = 32;

    localparam logic [FETCH_XLEN-1:0] PC_INC = 64'd4;

    typedef enum logic [1:0] {
        RUN   = 2'd0,  // free to request (credit permitting)
        WAIT  = 2'd1,  // one request outstanding, response is wanted
        DRAIN = 2'd2,  // one request outstanding, response will be dropped
        HALT  = 2'd3   // faulted or misaligned; wait for a flush
    } fetch_state_e;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_ILEN-1:0] ir;
        logic                  iam;
        logic                  iaf;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_unit_if.sv
// fetch_queue_unit_if: bundles the flush inputs, the instruction-cache
// request/response handshake and the decode handshake of the fetch stage.
//   master - the fetch unit's view (drives IC_REQ_* and DE_* outputs)
//   slave  - the environment's view (cache, decode, writeback, trap logic)
interface fetch_queue_unit_if #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned ILEN = 32
);

    logic            WB_REDIRECT_V;
    logic [XLEN-1:0] WB_REDIRECT_PC;
    logic            TRAP_V;
    logic [XLEN-1:0] DE_MTVEC;

    logic            IC_REQ_V;
    logic [XLEN-1:0] IC_REQ_PC;
    logic            IC_REQ_RDY;
    logic            IC_RSP_V;
    logic [ILEN-1:0] IC_RSP_INSTR;
    logic            IC_RSP_ERR;

    logic            DE_V;
    logic            DE_RDY;
    logic [ILEN-1:0] DE_IR;
    logic [XLEN-1:0] DE_PC;
    logic [XLEN-1:0] DE_NPC;
    logic            DE_IAM;
    logic            DE_IAF;

    modport master (
        input  WB_REDIRECT_V, WB_REDIRECT_PC, TRAP_V, DE_MTVEC,
        input  IC_REQ_RDY, IC_RSP_V, IC_RSP_INSTR, IC_RSP_ERR, DE_RDY,
        output IC_REQ_V, IC_REQ_PC,
        output DE_V, DE_IR, DE_PC, DE_NPC, DE_IAM, DE_IAF
    );

    modport slave (
        output WB_REDIRECT_V, WB_REDIRECT_PC, TRAP_V, DE_MTVEC,
        output IC_REQ_RDY, IC_RSP_V, IC_RSP_INSTR, IC_RSP_ERR, DE_RDY,
        input  IC_REQ_V, IC_REQ_PC,
        input  DE_V, DE_IR, DE_PC, DE_NPC, DE_IAM, DE_IAF
    );

endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of fetch_entry_t.
//   clk, rst      - clock, synchronous active-high reset
//   flush         - empty the queue; wins over push and pop
//   push/push_data- enqueue (ignored when full)
//   pop           - dequeue head (ignored when empty)
//   head          - current head entry (valid when !empty)
//   full/empty/count - occupancy status
module fetch_queue
    import fetch_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    output fetch_entry_t     head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // NOTE: every variable written here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        do_push  = push && !full && !flush;
        do_pop   = pop && !empty && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Power-of-two depth: pointers wrap by natural overflow.
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; an entry is only observed once count
    // says it was written, so resetting it would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: instruction-fetch stage. Issues PC-ordered requests to
// the instruction cache (at most one outstanding), buffers results in a
// DEPTH-entry queue and hands them to decode. Trap/redirect flush the
// queue and restart fetch; misaligned PCs and access faults become tagged
// entries followed by a halt until the next flush.
//   CLK, RESET - clock, synchronous active-high reset
//   bus        - fetch_queue_unit_if.master (flush, cache and decode ports)
module fetch_queue_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = 64,
    parameter int unsigned     ILEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 64'h0
) (
    input logic                CLK,
    input logic                RESET,
    fetch_queue_unit_if.master bus
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e     state_q, state_d;
    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;

    logic             flush, inflight, de_v;
    logic [XLEN-1:0]  flush_pc;
    logic             req_v;
    logic [XLEN-1:0]  req_pc;

    logic             q_push, q_pop, q_full, q_empty;
    logic [CNT_W-1:0] q_count;
    fetch_entry_t     q_wdata, q_head;

    assign flush    = bus.TRAP_V || bus.WB_REDIRECT_V;
    assign flush_pc = bus.TRAP_V ? bus.DE_MTVEC : bus.WB_REDIRECT_PC;
    assign inflight = (state_q == WAIT) || (state_q == DRAIN);
    assign de_v     = !q_empty && !RESET;
    assign q_pop    = de_v && bus.DE_RDY;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        q_push     = 1'b0;
        q_wdata    = '0;
        req_v      = 1'b0;
        req_pc     = fetch_pc_q;
        unique case (state_q)
            RUN: begin
                if (fetch_pc_q[1:0] != 2'b00) begin
                    // Misaligned target: report it in-order, never fetch it.
                    if (!q_full) begin
                        q_push      = 1'b1;
                        q_wdata.pc  = FETCH_XLEN'(fetch_pc_q);
                        q_wdata.iam = 1'b1;
                        state_d     = HALT;
                    end
                end else begin
                    req_v = !q_full;
                    if (req_v && bus.IC_REQ_RDY) state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.IC_RSP_V) begin
                    q_push      = 1'b1;
                    q_wdata.pc  = FETCH_XLEN'(fetch_pc_q);
                    q_wdata.ir  = bus.IC_RSP_ERR ? '0 : FETCH_ILEN'(bus.IC_RSP_INSTR);
                    q_wdata.iaf = bus.IC_RSP_ERR;
                    fetch_pc_d  = fetch_pc_q + XLEN'(PC_INC);
                    if (bus.IC_RSP_ERR) begin
                        state_d = HALT;
                    end else begin
                        // Back-to-back issue: the entry being pushed now
                        // occupies a slot, the retiring request frees none.
                        req_v   = (int'(q_count) + 1) < int'(DEPTH);
                        req_pc  = fetch_pc_d;
                        state_d = (req_v && bus.IC_REQ_RDY) ? WAIT : RUN;
                    end
                end
            end
            DRAIN: begin
                if (bus.IC_RSP_V) state_d = RUN;
            end
            HALT: begin
            end
            default: state_d = RUN;
        endcase
        if (flush) begin
            // A response landing in the flush cycle retires the request.
            q_push     = 1'b0;
            req_v      = 1'b0;
            fetch_pc_d = flush_pc;
            state_d    = (inflight && !bus.IC_RSP_V) ? DRAIN : RUN;
        end
        if (RESET) req_v = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk       (CLK),
        .rst       (RESET),
        .flush     (flush),
        .push      (q_push),
        .push_data (q_wdata),
        .pop       (q_pop),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    assign bus.IC_REQ_V  = req_v;
    assign bus.IC_REQ_PC = req_pc;

    // Idle decode outputs (reset or empty queue) show the reset PC.
    always_comb begin
        bus.DE_V   = de_v;
        bus.DE_IR  = '0;
        bus.DE_PC  = RESET_PC;
        bus.DE_NPC = RESET_PC + XLEN'(PC_INC);
        bus.DE_IAM = 1'b0;
        bus.DE_IAF = 1'b0;
        if (de_v) begin
            bus.DE_IR  = ILEN'(q_head.ir);
            bus.DE_PC  = XLEN'(q_head.pc);
            bus.DE_NPC = XLEN'(q_head.pc) + XLEN'(PC_INC);
            bus.DE_IAM = q_head.iam;
            bus.DE_IAF = q_head.iaf;
        end
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit: directed bench for fetch_queue_unit. The bench acts
// as instruction cache (configurable latency) and decode. Each accepted
// request is checked against the expected fetch PC; each delivered,
// non-discarded response is queued as an expected decode entry and
// compared when decode consumes the head.
module tb_fetch_queue_unit;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] ir;
        logic        iam;
        logic        iaf;
    } exp_t;

    logic CLK = 1'b0;
    logic RESET;

    fetch_queue_unit_if #(.XLEN(64), .ILEN(32)) bus ();

    fetch_queue_unit #(
        .XLEN(64), .ILEN(32), .DEPTH(DEPTH), .RESET_PC(64'h0)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    logic [63:0] exp_req_pc;
    bit          halted;
    bit          pend_v;
    logic [63:0] pend_pc;
    int          pend_wait;
    bit          pend_stale;
    int          rsp_lat = 1;
    bit          spurious = 0;
    logic [63:0] err_pc = '1;
    int          n_acc = 0;
    int          n_pop = 0;

    function automatic logic [31:0] instr_of(input logic [63:0] pc);
        return pc[31:0] ^ 32'hC0DE_0013;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic cycle();
        bit          flush, rsp_now, acc;
        exp_t        e;
        logic [63:0] tgt;
        rsp_now = pend_v && (pend_wait == 0);
        if (rsp_now) begin
            bus.IC_RSP_V     = 1'b1;
            bus.IC_RSP_INSTR = instr_of(pend_pc);
            bus.IC_RSP_ERR   = (pend_pc == err_pc);
        end else if (spurious) begin
            bus.IC_RSP_V     = 1'b1;
            bus.IC_RSP_INSTR = $urandom;
            bus.IC_RSP_ERR   = 1'b0;
        end else begin
            bus.IC_RSP_V     = 1'b0;
            bus.IC_RSP_INSTR = '0;
            bus.IC_RSP_ERR   = 1'b0;
        end
        #1;
        flush = bus.TRAP_V || bus.WB_REDIRECT_V;
        if (bus.DE_V) check("de_v_without_entry", sb.size() != 0, 1);
        if (bus.DE_V && bus.DE_RDY && !flush && sb.size() != 0) begin
            e = sb.pop_front();
            n_pop++;
            check("de_pc",  bus.DE_PC,  e.pc);
            check("de_npc", bus.DE_NPC, e.pc + 64'd4);
            check("de_ir",  bus.DE_IR,  e.ir);
            check("de_iam", bus.DE_IAM, e.iam);
            check("de_iaf", bus.DE_IAF, e.iaf);
        end
        if (rsp_now && !pend_stale && !flush) begin
            e.pc  = pend_pc;
            e.iaf = (pend_pc == err_pc);
            e.ir  = e.iaf ? 32'h0 : instr_of(pend_pc);
            e.iam = 1'b0;
            sb.push_back(e);
            if (e.iaf) halted = 1;
        end
        if (rsp_now) pend_v = 0;
        else if (pend_v) pend_wait--;
        acc = bus.IC_REQ_V && bus.IC_REQ_RDY;
        if (halted) check("req_while_halted", acc, 0);
        if (acc) begin
            check("req_pc", bus.IC_REQ_PC, exp_req_pc);
            check("one_outstanding", pend_v, 0);
            check("credit", sb.size() < DEPTH, 1);
            n_acc++;
            exp_req_pc = exp_req_pc + 64'd4;
            pend_v     = 1;
            pend_pc    = bus.IC_REQ_PC;
            pend_wait  = rsp_lat - 1;
            pend_stale = 0;
        end
        if (flush) begin
            tgt = bus.TRAP_V ? bus.DE_MTVEC : bus.WB_REDIRECT_PC;
            sb.delete();
            exp_req_pc = tgt;
            pend_stale = 1;
            halted     = (tgt[1:0] != 2'b00);
            if (halted) begin
                e.pc  = tgt;
                e.ir  = 32'h0;
                e.iam = 1'b1;
                e.iaf = 1'b0;
                sb.push_back(e);
            end
        end
        @(negedge CLK);
    endtask

    task automatic flush_cycle(input bit trap, input bit redir, input logic [63:0] pc);
        bus.TRAP_V         = trap;
        bus.WB_REDIRECT_V  = redir;
        bus.WB_REDIRECT_PC = pc;
        cycle();
        bus.TRAP_V         = 1'b0;
        bus.WB_REDIRECT_V  = 1'b0;
    endtask

    task automatic run_pops(input int n, input int budget, input string tag);
        int target;
        int k;
        target = n_pop + n;
        k = 0;
        while (n_pop < target && k < budget) begin
            cycle();
            k++;
        end
        check({tag, "_pops_in_time"}, n_pop >= target, 1);
    endtask

    task automatic wait_outstanding(input string tag);
        int k;
        k = 0;
        while (!(pend_v && pend_wait > 0) && k < 20) begin
            cycle();
            k++;
        end
        check({tag, "_outstanding"}, pend_v && pend_wait > 0, 1);
    endtask

    task automatic do_reset();
        RESET             = 1'b1;
        bus.TRAP_V        = 1'b0;
        bus.WB_REDIRECT_V = 1'b0;
        bus.IC_RSP_V      = 1'b0;
        bus.IC_RSP_ERR    = 1'b0;
        pend_v     = 0;
        pend_stale = 0;
        halted     = 0;
        exp_req_pc = 64'h0;
        sb.delete();
        repeat (2) @(negedge CLK);
        check("rst_de_v",   bus.DE_V,     0);
        check("rst_de_ir",  bus.DE_IR,    0);
        check("rst_de_pc",  bus.DE_PC,    64'h0);
        check("rst_de_npc", bus.DE_NPC,   64'h4);
        check("rst_de_iam", bus.DE_IAM,   0);
        check("rst_de_iaf", bus.DE_IAF,   0);
        check("rst_req_v",  bus.IC_REQ_V, 0);
        RESET = 1'b0;
    endtask

    initial begin
        int a0;
        int p0;
        bus.WB_REDIRECT_PC = '0;
        bus.DE_MTVEC       = 64'h800;
        bus.IC_REQ_RDY     = 1'b1;
        bus.IC_RSP_INSTR   = '0;
        bus.DE_RDY         = 1'b0;

        // Backpressure from reset: exactly DEPTH entries, then fetch stops.
        do_reset();
        a0 = n_acc;
        repeat (10) cycle();
        check("bp_accepted", n_acc - a0, DEPTH);
        check("bp_no_req", bus.IC_REQ_V, 0);
        check("bp_head_v", bus.DE_V, 1);
        check("bp_head_pc", bus.DE_PC, 64'h0);
        bus.DE_RDY = 1'b1;
        run_pops(5, 30, "bp_drain");

        // Straight-line fetch: first entry two cycles after the first request.
        do_reset();
        p0 = n_pop;
        repeat (2) cycle();
        check("sl_no_early_pop", n_pop, p0);
        cycle();
        check("sl_first_pop", n_pop, p0 + 1);
        repeat (7) cycle();
        check("sl_one_per_cycle", n_pop, p0 + 8);

        // Redirect while a slow request is outstanding; stale response dropped.
        rsp_lat = 3;
        wait_outstanding("redir");
        flush_cycle(1'b0, 1'b1, 64'h200);
        check("redir_de_v_low", bus.DE_V, 0);
        run_pops(3, 40, "redir");

        // Trap and redirect together: trap target wins.
        rsp_lat = 1;
        flush_cycle(1'b1, 1'b1, 64'h300);
        check("trap_de_v_low", bus.DE_V, 0);
        run_pops(3, 20, "trap");

        // Misaligned redirect: one tagged entry, then silence despite stray responses.
        flush_cycle(1'b0, 1'b1, 64'h102);
        run_pops(1, 10, "iam");
        a0 = n_acc;
        spurious = 1;
        repeat (8) cycle();
        spurious = 0;
        check("iam_no_req", n_acc - a0, 0);
        check("iam_queue_empty", bus.DE_V, 0);

        // Access fault on 0x40, halt, then trap to 0x80.
        err_pc = 64'h40;
        flush_cycle(1'b0, 1'b1, 64'h30);
        run_pops(5, 30, "iaf");
        a0 = n_acc;
        repeat (6) cycle();
        check("iaf_no_req", n_acc - a0, 0);
        err_pc = '1;
        bus.DE_MTVEC = 64'h80;
        flush_cycle(1'b1, 1'b0, 64'h0);
        bus.DE_MTVEC = 64'h800;
        run_pops(3, 20, "iaf_resume");

        // Reset with a request outstanding abandons it; fetch restarts at 0.
        rsp_lat = 3;
        flush_cycle(1'b0, 1'b1, 64'h500);
        wait_outstanding("rst_mid");
        do_reset();
        rsp_lat = 1;
        run_pops(2, 20, "rst_mid");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
